// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, field widths and
// the load-use match helper used by the hazard controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned PERF_W    = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_e;

  // True when a load in EX writes a non-zero register that the ID instruction reads.
  function automatic logic load_use_hit(
    input logic                 ex_mem_read,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] id_rs1,
    input logic                 id_uses_rs1,
    input logic [REG_IDX_W-1:0] id_rs2,
    input logic                 id_uses_rs2
  );
    return ex_mem_read && (ex_rd != '0) &&
           ((id_uses_rs1 && (ex_rd == id_rs1)) ||
            (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Ports: clk, rst_n (async clear), en_i (count this cycle), cnt_o (value).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use hazards,
// taken branches in EX and multi-cycle data-memory accesses, with a watchdog
// that halts the core when a memory access hangs.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ID_Rs1/ID_Rs2, ID_UsesRs1/2     ID source registers and their use flags
//   EX_Rd, EX_MemRead               EX destination and load flag
//   EX_BranchTaken                  taken branch/jump redirect in EX
//   MEM_MemReq, MEM_MemReady        outstanding data access / completion
//   PC_Write .. EX_MEM_Write        pipeline register advance enables (comb)
//   IF_ID_Flush, ID_EX_Flush        bubble insertion (comb)
//   MEM_WB_Bubble                   bubble into MEM/WB (comb)
//   MemTimeout, Halted              registered watchdog status
// Optional feature: define HAZARD_PERF_CNT_EN to add the StallCycles,
// FlushCount and LoadUseCount saturating performance counters.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] ID_Rs1,
  input  logic [REG_IDX_W-1:0] ID_Rs2,
  input  logic                 ID_UsesRs1,
  input  logic                 ID_UsesRs2,
  input  logic [REG_IDX_W-1:0] EX_Rd,
  input  logic                 EX_MemRead,
  input  logic                 EX_BranchTaken,
  input  logic                 MEM_MemReq,
  input  logic                 MEM_MemReady,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Write,
  output logic                 EX_MEM_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 MEM_WB_Bubble,
  output logic                 MemTimeout,
  output logic                 Halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    StallCycles,
  output logic [PERF_W-1:0]    FlushCount,
  output logic [PERF_W-1:0]    LoadUseCount
`endif
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q;
  logic             halted_q;
  logic             mem_stall;
  logic             load_use;

  assign mem_stall = MEM_MemReq && !MEM_MemReady;
  assign load_use  = load_use_hit(EX_MemRead, EX_Rd, ID_Rs1, ID_UsesRs1,
                                  ID_Rs2, ID_UsesRs2);

  // Next state, wait counter and same-cycle pipeline control.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;

    case (state_q)
      ST_HALT: begin
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;
      end
      default: begin
        if (mem_stall) begin
          // Freeze everything up to EX/MEM; a branch in EX stays put and
          // issues its flush in the release cycle.
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Write  = 1'b0;
          MEM_WB_Bubble = 1'b1;
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_HALT;
          end else begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
      end
    endcase

    // Pipeline is held idle while reset is asserted.
    if (!rst_n) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MEM_WB_Bubble = 1'b0;
    end
  end

  // State, wait counter and watchdog status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q || (state_d == ST_HALT);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign MemTimeout = mem_timeout_q;
  assign Halted     = halted_q;

`ifdef HAZARD_PERF_CNT_EN
  logic perf_live;
  logic stall_any;

  // Counters freeze once halted; IF_ID_Flush is only ever raised by a branch.
  assign perf_live = (state_q != ST_HALT);
  assign stall_any = !(PC_Write && IF_ID_Write && ID_EX_Write && EX_MEM_Write);

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (perf_live && stall_any),
    .cnt_o (StallCycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (perf_live && IF_ID_Flush),
    .cnt_o (FlushCount)
  );

  sat_counter #(.W(PERF_W)) u_load_use_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (perf_live && ID_EX_Flush && !IF_ID_Flush),
    .cnt_o (LoadUseCount)
  );
`endif

endmodule
